ffram_arbiter: RTL and testbench
================================

// Module: ffram_arbiter
// PURPOSE
//  Shares one flip-flop RAM (ffram storage) between NREQ requesters.
//  Each cycle at most one pending request is granted, chosen round-robin, and issued to the RAM.
//  Access result returns one cycle later to the granted requester only.
//  Sits between fabric-mapped user logic and the ffram storage in eFPGA benchmarks.
// PARAMETERS
//  NREQ   2  number of requesters (2..8)
//  AW     1  address width; RAM depth = 2**AW
//  DW     1  data width
// PORTS
//  clk      in   1         single clock, all state on rising edge
//  reset_n  in   1         asynchronous, active-low reset
//  req      in   NREQ      per-requester request; held high until granted
//  wen      in   NREQ      per-requester write enable (1=write, 0=read)
//  addr     in   NREQ*AW   per-requester address, slice i = [i*AW +: AW]
//  din      in   NREQ*DW   per-requester write data, slice i = [i*DW +: DW]
//  gnt      out  NREQ      one-hot grant, combinational, same cycle as accept
//  rvalid   out  NREQ      one-hot response strobe, cycle after grant
//  dout     out  DW        response data, valid when any rvalid bit set
// BEHAVIOUR
//  Reset (reset_n=0, async): all RAM words=0, rvalid=0, dout=0, rr pointer=0.
//   gnt is combinational; it is 0 while in reset.
//  Arbitration: search req starting at index ptr, ascending, wrapping NREQ-1->0.
//   First set bit wins. gnt = onehot(winner), or 0 if req==0.
//   gnt[i] never set when req[i]=0. At most one gnt bit per cycle.
//  Pointer: on a grant to i, ptr <= (i+1) mod NREQ.
//   No grant: ptr holds. NREQ non-power-of-2 must wrap correctly.
//  Issue: the winner's wen/addr/din drive the RAM in the grant cycle; req itself is never latched.
//  RAM (registered output, write-first):
//   write: mem[a]<=d and dout<=d.
//   read: dout<=mem[a].
//   no grant: dout holds its previous value.
//  Response: rvalid <= gnt (registered), for reads and writes alike. Latency = 1 cycle.
//   Requester may drop req or present a new one in the cycle after gnt.
//   Back-to-back grants to different requesters give back-to-back rvalid.
//  Same-address hazard: a read granted the cycle after a write to that address returns the new data.
//  Requester dropping req before grant: request withdrawn, no side effect.
//  Reset mid-access: the pending rvalid is cleared and the write in flight at reset assertion is lost.
//   Memory is cleared regardless.
//  Out-of-range requests do not occur (addr covers exactly 2**AW).
// STRUCTURE
//  Package ffram_arb_pkg: localparam for PTR_W = $clog2(NREQ), plus function rr_pick(req, ptr) returning one-hot grant.
//  Sub-module ffram_core (AW, DW): async-reset storage, write-first registered dout, ports clk/reset_n/en/wen/addr/din/dout.
//  Top: rr_pick + ptr register + issue mux + rvalid register.
// TESTING
//  T1 reset: hold reset_n=0 two cycles -> gnt=0, rvalid=0, dout=0; then read addr 0 and 1 by req0 -> dout=0 both.
//  T2 single write/read: req0 wen=1 addr=0 din=1 -> gnt=01 same cycle, next cycle rvalid=01 dout=1.
//   Then req0 read addr=1 -> dout=0.
//  T3 contention: req=11 held three cycles, ptr=0 -> grants 01,10,01; rvalid follows one cycle later.
//   ptr ends at 1.
//  T4 write-then-read hazard: req1 write addr=1 din=1, next cycle req0 read addr=1 -> rvalid=01 with dout=1.
//  T5 async reset mid-access: write addr=0 din=1 granted, drop reset_n before the next edge.
//   -> rvalid=0 immediately, then reading addr 0 gives 0.
//  T6 NREQ=3 build: req=101 repeatedly -> grants alternate 001,100,001; requester 1 never granted.
//   Idle cycles leave ptr and dout unchanged.
//  Bench counts mismatches and prints pass/fail summary.

Source files
------------

// File: rtl/ffram_arbiter_pkg.sv
// Shared constants and the round-robin pick function for the ffram arbiter.
package ffram_arb_pkg;

  localparam int unsigned MAX_NREQ = 8;
  localparam int unsigned PTR_W    = $clog2(MAX_NREQ);

  // Scan from ptr upwards, wrapping at n (not at MAX_NREQ), first set bit wins.
  function automatic logic [MAX_NREQ-1:0] rr_pick(input logic [MAX_NREQ-1:0] req,
                                                  input logic [PTR_W-1:0]    ptr,
                                                  input int unsigned         n);
    logic [MAX_NREQ-1:0] g;
    logic                found;
    logic [PTR_W-1:0]    idx;
    g     = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_NREQ; k++) begin
      idx = PTR_W'((32'(ptr) + k) % n);
      if (k < n && !found && req[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/ffram_arbiter_if.sv
// Requester-side bus of the ffram arbiter: packed per-requester request fields plus shared response.
interface ffram_arbiter_if #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned AW   = 1,
  parameter int unsigned DW   = 1
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    wen;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] din;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      dout;

  modport master (output req, wen, addr, din, input gnt, rvalid, dout);
  modport slave  (input req, wen, addr, din, output gnt, rvalid, dout);
endinterface

// File: rtl/ffram_arbiter_core.sv
// Flip-flop RAM with async clear and a write-first registered read port.
module ffram_core #(
  parameter int unsigned AW = 1,
  parameter int unsigned DW = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic          wen,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);
  localparam int unsigned DEPTH = 2**AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] dout_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      dout_q <= '0;
    end else if (en) begin
      if (wen) begin
        mem_q[addr] <= din;
        dout_q      <= din;
      end else begin
        dout_q <= mem_q[addr];
      end
    end
  end

  assign dout = dout_q;
endmodule

// File: rtl/ffram_arbiter.sv
// Round-robin arbiter sharing one ffram_core between NREQ requesters; one-cycle response latency.
module ffram_arbiter
  import ffram_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned AW   = 1,
  parameter int unsigned DW   = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  ffram_arbiter_if.slave bus
);
  logic [NREQ-1:0]  gnt;
  logic [PTR_W-1:0] ptr_q, ptr_d, win;
  logic             sel_wen;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_din;
  logic [NREQ-1:0]  rvalid_q;
  logic [DW-1:0]    core_dout;

  always_comb begin
    // Grant is forced low while reset is asserted so nothing is issued to the clearing RAM.
    gnt      = reset_n ? NREQ'(rr_pick(MAX_NREQ'(bus.req), ptr_q, NREQ)) : '0;
    win      = '0;
    sel_wen  = 1'b0;
    sel_addr = '0;
    sel_din  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        win      = PTR_W'(i);
        sel_wen  = bus.wen[i];
        sel_addr = bus.addr[i*AW +: AW];
        sel_din  = bus.din[i*DW +: DW];
      end
    end
    ptr_d = ptr_q;
    if (|gnt) ptr_d = (32'(win) == NREQ - 1) ? '0 : win + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q    <= '0;
      rvalid_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      rvalid_q <= gnt;
    end
  end

  ffram_core #(.AW(AW), .DW(DW)) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (|gnt),
    .wen     (sel_wen),
    .addr    (sel_addr),
    .din     (sel_din),
    .dout    (core_dout)
  );

  assign bus.gnt    = gnt;
  assign bus.rvalid = rvalid_q;
  assign bus.dout   = core_dout;
endmodule

// File: tb/tb_ffram_arbiter.sv
// Directed bench for ffram_arbiter: NREQ=2 and NREQ=3 instances, response scoreboard per instance.
module tb_ffram_arbiter;

  typedef struct {
    logic [2:0] g;
    logic       d;
  } resp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ffram_arbiter_if #(.NREQ(2), .AW(1), .DW(1)) ifa ();
  ffram_arbiter_if #(.NREQ(3), .AW(1), .DW(1)) ifb ();

  ffram_arbiter #(.NREQ(2), .AW(1), .DW(1)) dut_a (.clk(clk), .reset_n(rst_n), .bus(ifa.slave));
  ffram_arbiter #(.NREQ(3), .AW(1), .DW(1)) dut_b (.clk(clk), .reset_n(rst_n), .bus(ifb.slave));

  logic  mem_a [2];
  logic  mem_b [2];
  logic  last_a, last_b;
  resp_t qa[$];
  resp_t qb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step_a(input string tag, input logic [1:0] r, input logic [1:0] w,
                        input logic [1:0] ad, input logic [1:0] di, input logic [1:0] eg);
    resp_t e;
    int    idx;
    @(negedge clk);
    ifa.req = r; ifa.wen = w; ifa.addr = ad; ifa.din = di;
    #1 chk({tag, ".gnt"}, 32'(ifa.gnt), 32'(eg));
    if (eg != 2'b00) begin
      idx = eg[1] ? 1 : 0;
      e.g = {1'b0, eg};
      if (w[idx]) begin mem_a[ad[idx]] = di[idx]; e.d = di[idx]; end
      else e.d = mem_a[ad[idx]];
      qa.push_back(e);
    end
    @(posedge clk);
    #1;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      chk({tag, ".rvalid"}, 32'(ifa.rvalid), 32'(e.g));
      chk({tag, ".dout"}, 32'(ifa.dout), 32'(e.d));
      last_a = e.d;
    end else begin
      chk({tag, ".rvalid_idle"}, 32'(ifa.rvalid), 32'd0);
      chk({tag, ".dout_hold"}, 32'(ifa.dout), 32'(last_a));
    end
  endtask

  task automatic step_b(input string tag, input logic [2:0] r, input logic [2:0] w,
                        input logic [2:0] ad, input logic [2:0] di, input logic [2:0] eg);
    resp_t e;
    int    idx;
    @(negedge clk);
    ifb.req = r; ifb.wen = w; ifb.addr = ad; ifb.din = di;
    #1 chk({tag, ".gnt"}, 32'(ifb.gnt), 32'(eg));
    if (eg != 3'b000) begin
      idx = 0;
      for (int i = 0; i < 3; i++) if (eg[i]) idx = i;
      e.g = eg;
      if (w[idx]) begin mem_b[ad[idx]] = di[idx]; e.d = di[idx]; end
      else e.d = mem_b[ad[idx]];
      qb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (qb.size() > 0) begin
      e = qb.pop_front();
      chk({tag, ".rvalid"}, 32'(ifb.rvalid), 32'(e.g));
      chk({tag, ".dout"}, 32'(ifb.dout), 32'(e.d));
      last_b = e.d;
    end else begin
      chk({tag, ".rvalid_idle"}, 32'(ifb.rvalid), 32'd0);
      chk({tag, ".dout_hold"}, 32'(ifb.dout), 32'(last_b));
    end
  endtask

  task automatic model_reset();
    mem_a[0] = 1'b0; mem_a[1] = 1'b0; mem_b[0] = 1'b0; mem_b[1] = 1'b0;
    last_a = 1'b0; last_b = 1'b0;
    qa.delete(); qb.delete();
  endtask

  initial begin
    ifa.req = '0; ifa.wen = '0; ifa.addr = '0; ifa.din = '0;
    ifb.req = '0; ifb.wen = '0; ifb.addr = '0; ifb.din = '0;
    model_reset();

    // T1: reset state, request ignored during reset
    repeat (2) @(posedge clk);
    ifa.req = 2'b01;
    #1;
    chk("t1.gnt_in_reset", 32'(ifa.gnt), 32'd0);
    chk("t1.rvalid", 32'(ifa.rvalid), 32'd0);
    chk("t1.dout", 32'(ifa.dout), 32'd0);
    chk("t1.b_gnt", 32'(ifb.gnt), 32'd0);
    @(negedge clk);
    ifa.req = 2'b00;
    rst_n = 1'b1;
    step_a("t1.rd0", 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
    step_a("t1.rd1", 2'b01, 2'b00, 2'b01, 2'b00, 2'b01);

    // T2: single write then reads
    step_a("t2.wr0", 2'b01, 2'b01, 2'b00, 2'b01, 2'b01);
    step_a("t2.rd1", 2'b01, 2'b00, 2'b01, 2'b00, 2'b01);
    step_a("t2.rd0", 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
    step_a("t2.idle", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

    // T3: bring ptr back to 0, then contention; req0 reads a0, req1 writes a1=1
    step_a("t3.align", 2'b10, 2'b00, 2'b00, 2'b00, 2'b10);
    step_a("t3.c0", 2'b11, 2'b10, 2'b10, 2'b10, 2'b01);
    step_a("t3.c1", 2'b11, 2'b10, 2'b10, 2'b10, 2'b10);
    step_a("t3.c2", 2'b11, 2'b10, 2'b10, 2'b10, 2'b01);
    step_a("t3.ptr1", 2'b11, 2'b00, 2'b10, 2'b00, 2'b10);

    // T4: write-then-read hazard, back-to-back rvalid across requesters
    step_a("t4.wr_d0", 2'b10, 2'b10, 2'b10, 2'b00, 2'b10);
    step_a("t4.rd_d0", 2'b01, 2'b00, 2'b01, 2'b00, 2'b01);
    step_a("t4.wr_d1", 2'b10, 2'b10, 2'b10, 2'b10, 2'b10);
    step_a("t4.rd_d1", 2'b01, 2'b00, 2'b01, 2'b00, 2'b01);

    // T5a: write granted, reset before its edge -> write never lands
    @(negedge clk);
    ifa.req = 2'b01; ifa.wen = 2'b01; ifa.addr = 2'b00; ifa.din = 2'b01;
    #1 chk("t5a.gnt", 32'(ifa.gnt), 32'b01);
    #1 rst_n = 1'b0;
    #1 chk("t5a.gnt_rst", 32'(ifa.gnt), 32'd0);
    chk("t5a.dout_rst", 32'(ifa.dout), 32'd0);
    model_reset();
    @(negedge clk);
    ifa.req = 2'b00;
    rst_n = 1'b1;
    step_a("t5a.rd0", 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
    step_a("t5a.rd1", 2'b10, 2'b00, 2'b10, 2'b00, 2'b10);

    // T5b: rvalid pending when reset drops -> cleared immediately, memory cleared
    step_a("t5b.wr0", 2'b01, 2'b01, 2'b00, 2'b01, 2'b01);
    #2 rst_n = 1'b0;
    #1 chk("t5b.rvalid_rst", 32'(ifa.rvalid), 32'd0);
    chk("t5b.dout_rst", 32'(ifa.dout), 32'd0);
    model_reset();
    @(negedge clk);
    ifa.req = 2'b00;
    rst_n = 1'b1;
    step_a("t5b.rd0", 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);

    // T6: NREQ=3 skip over requester 1, idle holds ptr and dout, wrap from 2 to 0
    step_b("t6.g0", 3'b101, 3'b001, 3'b000, 3'b001, 3'b001);
    step_b("t6.g2", 3'b101, 3'b000, 3'b000, 3'b000, 3'b100);
    step_b("t6.g0b", 3'b101, 3'b001, 3'b000, 3'b001, 3'b001);
    step_b("t6.idle", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    step_b("t6.g2b", 3'b101, 3'b000, 3'b000, 3'b000, 3'b100);
    step_b("t6.g1", 3'b110, 3'b000, 3'b000, 3'b000, 3'b010);
    step_b("t6.wrap", 3'b011, 3'b000, 3'b000, 3'b000, 3'b001);
    step_b("t6.idle2", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
